// File: rtl/conversor_bcd_if.sv
// Handshake and data bundle between the adder result source and the BCD converter.
// master drives the start request and operand; slave returns status and BCD digits.
interface conversor_bcd_if #(
    parameter int LARGURA = 6
);
    logic               inicio;
    logic               com_sinal;
    logic [LARGURA-1:0] entrada;
    logic               ocupado;
    logic               pronto;
    logic               negativo;
    logic [3:0]         centenas;
    logic [3:0]         dezenas;
    logic [3:0]         unidades;

    modport master (
        output inicio, com_sinal, entrada,
        input  ocupado, pronto, negativo, centenas, dezenas, unidades
    );

    modport slave (
        input  inicio, com_sinal, entrada,
        output ocupado, pronto, negativo, centenas, dezenas, unidades
    );
endinterface

// File: rtl/conversor_bcd.sv
// Iterative shift-add-3 binary to sign + BCD converter; pronto LARGURA+1 cycles after start.
// Starts are ignored while busy and in the pronto cycle; outputs hold until the next result.
module conversor_bcd #(
    parameter int LARGURA = 6,
    parameter int DIGITOS = 3
) (
    input  logic           clock,
    input  logic           reset,
    conversor_bcd_if.slave bus
);
    localparam int DW = 4 * DIGITOS;
    localparam int CW = $clog2(LARGURA + 1);

    typedef enum logic [1:0] {OCIOSO, CONVERTE, PRONTO} estado_t;

    estado_t            estado_q;
    logic [CW-1:0]      cont_q;
    logic [LARGURA-1:0] mag_q, mag_d, mag_ent;
    logic [DW-1:0]      dig_q, dig_d, dig_adj;
    logic               neg_int_q, neg_ent;
    logic               ocupado_q, pronto_q, negativo_q;
    logic [3:0]         centenas_q, dezenas_q, unidades_q;

    // Negative two's complement inputs are converted on their magnitude; -2^(L-1) maps to 2^(L-1).
    assign neg_ent = bus.com_sinal && bus.entrada[LARGURA-1];
    assign mag_ent = neg_ent ? (LARGURA'(0) - bus.entrada) : bus.entrada;

    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < DIGITOS; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
        {dig_d, mag_d} = {dig_adj, mag_q} << 1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            cont_q     <= '0;
            mag_q      <= '0;
            dig_q      <= '0;
            neg_int_q  <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
            negativo_q <= 1'b0;
            centenas_q <= 4'd0;
            dezenas_q  <= 4'd0;
            unidades_q <= 4'd0;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    // The cycle showing pronto is not a start opportunity.
                    if (bus.inicio && !pronto_q) begin
                        mag_q     <= mag_ent;
                        neg_int_q <= neg_ent;
                        dig_q     <= '0;
                        cont_q    <= CW'(LARGURA);
                        ocupado_q <= 1'b1;
                        estado_q  <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    dig_q  <= dig_d;
                    mag_q  <= mag_d;
                    cont_q <= cont_q - CW'(1);
                    if (cont_q == CW'(1)) begin
                        estado_q <= PRONTO;
                    end
                end
                PRONTO: begin
                    centenas_q <= dig_q[11:8];
                    dezenas_q  <= dig_q[7:4];
                    unidades_q <= dig_q[3:0];
                    negativo_q <= neg_int_q;
                    pronto_q   <= 1'b1;
                    ocupado_q  <= 1'b0;
                    estado_q   <= OCIOSO;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.ocupado  = ocupado_q;
    assign bus.pronto   = pronto_q;
    assign bus.negativo = negativo_q;
    assign bus.centenas = centenas_q;
    assign bus.dezenas  = dezenas_q;
    assign bus.unidades = unidades_q;
endmodule

// File: doc/conversor_bcd.md
Name: conversor_bcd

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the 4-bit adder/subtractor (somador4).
- Takes its 6-bit result, signed or unsigned, and produces sign plus hundreds/tens/units BCD digits for the 7-segment decoders (decodificador).
- Replaces the combinational /100, %10 chain with an iterative shift-add-3 (double dabble) FSM with a start/done handshake.

Parameters:
- LARGURA, 6, width of the binary input. Supported range 1..9, so the result always fits 3 BCD digits.
- DIGITOS, 3, number of BCD output digits. Fixed at 3 for this revision.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous reset, active-high.
- inicio  input  1  start request, sampled only in OCIOSO.
- com_sinal  input  1  1 = entrada is two's complement; 0 = entrada is unsigned.
- entrada  input  LARGURA  binary value to convert (somador4 S output).
- ocupado  output  1  high while a conversion is in progress.
- pronto  output  1  one-cycle pulse when new digits are valid.
- negativo  output  1  sign of the last converted value.
- centenas  output  4  BCD hundreds digit.
- dezenas  output  4  BCD tens digit.
- unidades  output  4  BCD units digit.

Behaviour:
- Reset: synchronous, active-high, takes priority over everything including mid-conversion.
  - FSM returns to OCIOSO; the conversion in flight is discarded.
  - ocupado=0, pronto=0, negativo=0, centenas/dezenas/unidades=0.
- FSM states:
  - OCIOSO: if inicio=1, latch the operands, go to CONVERTE, load counter=LARGURA.
    - Magnitude and sign: if com_sinal=1 and entrada[MSB]=1, magnitude = two's complement negation of entrada taken as LARGURA-bit unsigned (-32 -> 32), and negativo_int=1.
    - Otherwise magnitude = entrada and negativo_int=0.
    - Internal digit shift register cleared.
  - CONVERTE: one bit per cycle.
    - First, each 4-bit digit >=5 gets +3.
    - Then {digits, magnitude} shifts left by 1.
    - Counter decrements; at counter==1 the final shift happens and the FSM goes to PRONTO.
  - PRONTO: output registers load the digits and negativo_int; pronto=1 for exactly this cycle; next state OCIOSO.
- Timing:
  - ocupado=1 in CONVERTE and PRONTO.
  - Latency: inicio sampled at edge N gives pronto high during the cycle after edge N+LARGURA+1, so LARGURA+1 cycles after capture (7 for default).
- Outputs hold their last converted value until the next PRONTO; they are not cleared at inicio.
- inicio while ocupado=1 is ignored and not queued. entrada/com_sinal changes after capture have no effect.
- Back-to-back operation: inicio high in the cycle pronto=1 is ignored. The next accepted start is the first OCIOSO cycle with inicio=1.
- Zero: negativo=0, all digits 0, even when com_sinal=1.
- Digit width rules:
  - Every output digit is always a legal BCD value 0..9.
  - For LARGURA=6, centenas is always 0 (max magnitude 63).

Test Plan:
- Reset, then entrada=6'd0, com_sinal=0, inicio pulse -> pronto after 7 cycles; negativo=0, digits 0,0,0; ocupado high exactly 7 cycles.
- entrada=6'd63, com_sinal=0 -> centenas=0, dezenas=6, unidades=3, negativo=0.
- Signed cases, com_sinal=1:
  - entrada=6'b111011 -> negativo=1, 0,0,5.
  - entrada=6'b100000 -> negativo=1, 0,3,2.
  - entrada=6'b011111 -> negativo=0, 0,3,1.
- Convert 6'd30; 2 cycles after start, pulse inicio with entrada=6'd7 -> second request ignored. Result 0,3,0; pronto pulses once; outputs stay 0,3,0 afterwards.
- Start conversion of 6'd45; assert reset on the 4th CONVERTE cycle -> next cycle ocupado=0, pronto=0, digits 0,0,0. No pronto pulse follows. A fresh start converting 6'd12 gives 0,1,2.
- Sweep all 64 entrada values in both com_sinal modes against a reference model -> digits, negativo, and latency match for every value; no digit is ever >9.
